// File: rtl/disp_mux_if.sv
// Digit-source / display-driver connection for disp_mux.
// The master side supplies scan control and the BCD digit registers.
// The slave side (disp_mux) returns the anode, segment and frame-tick outputs.
interface disp_mux_if;
    logic       enable;
    logic       lz_blank;
    logic [3:0] bcd_0;
    logic [3:0] bcd_1;
    logic [3:0] bcd_2;
    logic [3:0] bcd_3;
    logic [3:0] dp_in;
    logic [3:0] an;
    logic [7:0] sseg;
    logic       frame_tick;

    modport master (
        output enable,
        output lz_blank,
        output bcd_0,
        output bcd_1,
        output bcd_2,
        output bcd_3,
        output dp_in,
        input  an,
        input  sseg,
        input  frame_tick
    );

    modport slave (
        input  enable,
        input  lz_blank,
        input  bcd_0,
        input  bcd_1,
        input  bcd_2,
        input  bcd_3,
        input  dp_in,
        output an,
        output sseg,
        output frame_tick
    );
endinterface

// File: rtl/disp_mux.sv
// Time-multiplexed driver for a 4-digit common-anode 7-segment display.
// The digit set is captured into shadow registers once per scan frame, so a
// frame never mixes old and new digits. Each digit slot starts with a short
// all-anodes-off guard interval to suppress ghosting between digits.
module disp_mux #(
    parameter int POWER = 18,
    parameter int GUARD = 64
) (
    input  logic      clk,
    input  logic      reset_n,
    disp_mux_if.slave bus
);

    localparam int SLOT_W = POWER - 2;

    localparam logic [SLOT_W-1:0] GUARD_W   = SLOT_W'(GUARD);
    localparam logic [POWER-1:0]  Q_LAST    = {POWER{1'b1}};
    localparam logic [6:0]        SEG_BLANK = 7'h7F;
    localparam logic [6:0]        SEG_DASH  = 7'h3F;

    logic [POWER-1:0]  q;
    logic [1:0]        slot;
    logic [SLOT_W-1:0] slot_pos;
    logic              frame_end;
    logic              in_guard;

    logic [3:0][3:0]   shadow_d;
    logic [3:0]        shadow_dp;

    logic [3:0]        digit_sel;
    logic              dp_sel;
    logic              blank;
    logic [6:0]        seg_code;

    logic [3:0]        an_next;
    logic [7:0]        sseg_next;

    // BCD to active-low {g,f,e,d,c,b,a}; codes above 9 render as a dash.
    function automatic logic [6:0] bcd_to_seg(input logic [3:0] code);
        logic [6:0] seg;
        seg = SEG_DASH;
        case (code)
            4'd0: seg = 7'h40;
            4'd1: seg = 7'h79;
            4'd2: seg = 7'h24;
            4'd3: seg = 7'h30;
            4'd4: seg = 7'h19;
            4'd5: seg = 7'h12;
            4'd6: seg = 7'h02;
            4'd7: seg = 7'h78;
            4'd8: seg = 7'h00;
            4'd9: seg = 7'h10;
            default: seg = SEG_DASH;
        endcase
        return seg;
    endfunction

    assign slot      = q[POWER-1:POWER-2];
    assign slot_pos  = q[POWER-3:0];
    assign frame_end = bus.enable && (q == Q_LAST);

    // A zero guard length removes the blanking window entirely.
    generate
        if (GUARD == 0) begin : g_no_guard
            assign in_guard = 1'b0;
        end else begin : g_guard
            assign in_guard = (slot_pos < GUARD_W);
        end
    endgenerate

    // Refresh counter: free-runs while enabled, frozen otherwise.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q <= '0;
        end else if (bus.enable) begin
            q <= q + 1'b1;
        end
    end

    // Shadow capture of the digit set on the last count of each frame.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shadow_d  <= '0;
            shadow_dp <= '0;
        end else if (frame_end) begin
            shadow_d  <= {bus.bcd_3, bus.bcd_2, bus.bcd_1, bus.bcd_0};
            shadow_dp <= bus.dp_in;
        end
    end

    // Select the digit for the current slot and decide leading-zero blanking.
    always_comb begin
        digit_sel = shadow_d[slot];
        dp_sel    = shadow_dp[slot];
        blank     = 1'b0;
        if (bus.lz_blank) begin
            case (slot)
                2'd3:    blank = (shadow_d[3] == 4'd0);
                2'd2:    blank = (shadow_d[3] == 4'd0) && (shadow_d[2] == 4'd0);
                2'd1:    blank = (shadow_d[3] == 4'd0) && (shadow_d[2] == 4'd0)
                              && (shadow_d[1] == 4'd0);
                default: blank = 1'b0;
            endcase
        end
        seg_code = blank ? SEG_BLANK : bcd_to_seg(digit_sel);
    end

    // Next anode/segment pattern; dark whenever the scan is halted.
    always_comb begin
        an_next   = 4'b1111;
        sseg_next = 8'hFF;
        if (bus.enable) begin
            sseg_next = {~dp_sel, seg_code};
            if (!in_guard) begin
                an_next = ~(4'b0001 << slot);
            end
        end
    end

    // Registered display outputs and the frame tick.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.an         <= 4'b1111;
            bus.sseg       <= 8'hFF;
            bus.frame_tick <= 1'b0;
        end else begin
            bus.an         <= an_next;
            bus.sseg       <= sseg_next;
            bus.frame_tick <= frame_end;
        end
    end

endmodule

// File: tb/tb_disp_mux.sv
// Bench for disp_mux with POWER=6, GUARD=2 (16-clock slots, 64-clock frames).
module tb_disp_mux;

    localparam int FRAME = 64;
    localparam int SLOT  = 16;
    localparam int GRD   = 2;

    logic clk = 1'b0;
    logic reset_n;

    always #5 clk = ~clk;

    disp_mux_if dif ();

    disp_mux #(.POWER(6), .GUARD(GRD)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (dif.slave)
    );

    int checks = 0;
    int errors = 0;

    // Behavioural model: frame position plus the captured digit set.
    int mq;
    int sh[4];
    int sdp;
    int e_an, e_sseg, e_ft;
    int seg7[16] = '{'h40, 'h79, 'h24, 'h30, 'h19, 'h12, 'h02, 'h78,
                     'h00, 'h10, 'h3F, 'h3F, 'h3F, 'h3F, 'h3F, 'h3F};
    int ft_count;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic reset_model();
        mq  = 0;
        sdp = 0;
        for (int k = 0; k < 4; k++) sh[k] = 0;
    endtask

    task automatic set_digits(input int d3, input int d2, input int d1, input int d0, input int dp);
        dif.bcd_3 = 4'(d3);
        dif.bcd_2 = 4'(d2);
        dif.bcd_1 = 4'(d1);
        dif.bcd_0 = 4'(d0);
        dif.dp_in = 4'(dp);
    endtask

    // One clock: predict outputs from the model, advance, compare.
    task automatic step();
        int slot, off, digit, seg;
        bit blank;
        slot = mq / SLOT;
        off  = mq % SLOT;
        if (!dif.enable) begin
            e_an   = 'hF;
            e_sseg = 'hFF;
        end else begin
            e_an  = (off < GRD) ? 'hF : ('hF & ~(1 << slot));
            digit = sh[slot];
            blank = 1'b0;
            if (dif.lz_blank && slot > 0) begin
                blank = 1'b1;
                for (int k = slot; k < 4; k++) if (sh[k] != 0) blank = 1'b0;
            end
            seg    = blank ? 'h7F : seg7[digit];
            e_sseg = (((sdp >> slot) & 1) != 0 ? 0 : 'h80) | seg;
        end
        e_ft = (dif.enable && mq == FRAME - 1) ? 1 : 0;
        if (dif.enable) begin
            if (mq == FRAME - 1) begin
                sh[0] = int'(dif.bcd_0);
                sh[1] = int'(dif.bcd_1);
                sh[2] = int'(dif.bcd_2);
                sh[3] = int'(dif.bcd_3);
                sdp   = int'(dif.dp_in);
            end
            mq = (mq + 1) % FRAME;
        end
        @(posedge clk);
        #1;
        chk("an", dif.an, e_an);
        chk("sseg", dif.sseg, e_sseg);
        chk("frame_tick", dif.frame_tick, e_ft);
        if (dif.frame_tick) ft_count++;
    endtask

    initial begin
        int ref_sseg2[4];
        int ref_an[4];
        reset_n      = 1'b0;
        dif.enable   = 1'b0;
        dif.lz_blank = 1'b0;
        set_digits(1, 2, 3, 4, 'b0010);
        reset_model();
        ft_count = 0;

        // Reset state
        #22;
        chk("rst_an", dif.an, 'hF);
        chk("rst_sseg", dif.sseg, 'hFF);
        chk("rst_ft", dif.frame_tick, 0);

        @(posedge clk);
        #1;
        reset_n    = 1'b1;
        dif.enable = 1'b1;

        // Frame 1: shadows still zero, guard then "0" on digit 0
        for (int i = 1; i <= FRAME; i++) begin
            step();
            if (i <= GRD) chk("f1_guard_an", dif.an, 'hF);
            else if (i <= SLOT) begin
                chk("f1_an", dif.an, 'hE);
                chk("f1_sseg", dif.sseg, 'hC0);
            end
            if (i < FRAME) chk("f1_no_tick", dif.frame_tick, 0);
        end
        chk("f1_tick", dif.frame_tick, 1);

        // Frame 2: digits 1,2,3,4 with dp on digit 1; bcd_0 changes mid-slot-0
        ref_sseg2 = '{'h99, 'h30, 'hA4, 'hF9};
        ref_an    = '{'hE, 'hD, 'hB, 'h7};
        for (int i = 1; i <= FRAME; i++) begin
            if (i == 5) dif.bcd_0 = 4'd9;
            step();
            if ((i - 1) % SLOT == 8) begin
                chk("f2_sseg", dif.sseg, ref_sseg2[(i - 1) / SLOT]);
                chk("f2_an", dif.an, ref_an[(i - 1) / SLOT]);
            end
        end
        chk("tick_count", ft_count, 2);

        // Frame 3: new digit 0 shows 9; load leading-zero pattern 0,0,0,7
        for (int i = 1; i <= FRAME; i++) begin
            step();
            if (i == 9) chk("f3_new_digit", dif.sseg, 'h90);
            if (i == 20) begin
                dif.lz_blank = 1'b1;
                set_digits(0, 0, 0, 7, 0);
            end
        end

        // Frame 4: slots 3..1 blank, slot 0 shows 7; then load 0,5,0,0
        for (int i = 1; i <= FRAME; i++) begin
            step();
            if (i == 9)  chk("f4_s0", dif.sseg, 'hF8);
            if (i == 25) chk("f4_s1", dif.sseg, 'hFF);
            if (i == 41) chk("f4_s2", dif.sseg, 'hFF);
            if (i == 57) chk("f4_s3", dif.sseg, 'hFF);
            if (i == 30) set_digits(0, 5, 0, 0, 0);
        end

        // Frame 5: slot 3 blank, 5 0 0 shown; then load dash in digit 2
        for (int i = 1; i <= FRAME; i++) begin
            step();
            if (i == 9)  chk("f5_s0", dif.sseg, 'hC0);
            if (i == 25) chk("f5_s1", dif.sseg, 'hC0);
            if (i == 41) chk("f5_s2", dif.sseg, 'h92);
            if (i == 57) chk("f5_s3", dif.sseg, 'hFF);
            if (i == 30) set_digits(0, 'hC, 0, 0, 0);
        end

        // Frame 6: dash is non-zero, never blanked
        for (int i = 1; i <= FRAME; i++) begin
            step();
            if (i == 25) chk("f6_s1", dif.sseg, 'hC0);
            if (i == 41) chk("f6_dash", dif.sseg, 'hBF);
            if (i == 57) chk("f6_s3", dif.sseg, 'hFF);
        end

        // Enable drop at q=20 for 10 clocks, resume in slot 1
        dif.lz_blank = 1'b0;
        set_digits(8, 6, 3, 1, 'b1001);
        while (mq != 20) step();
        dif.enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("halt_an", dif.an, 'hF);
            chk("halt_sseg", dif.sseg, 'hFF);
        end
        dif.enable = 1'b1;
        step();
        chk("resume_an", dif.an, 'hD);
        chk("resume_tick", dif.frame_tick, 0);

        // Async reset in slot 2
        while (mq != 40) step();
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_an", dif.an, 'hF);
        chk("async_sseg", dif.sseg, 'hFF);
        chk("async_ft", dif.frame_tick, 0);
        reset_model();
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Randomized frames against the model
        for (int i = 0; i < 6 * FRAME; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                set_digits($urandom_range(0, 1) ? 0 : $urandom_range(0, 15),
                           $urandom_range(0, 1) ? 0 : $urandom_range(0, 15),
                           $urandom_range(0, 1) ? 0 : $urandom_range(0, 15),
                           $urandom_range(0, 15), $urandom_range(0, 15));
            end
            if ($urandom_range(0, 15) == 0) dif.lz_blank = ~dif.lz_blank;
            dif.enable = ($urandom_range(0, 9) != 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
